nibble_serial_adder: RTL

Multi-cycle operand sequencer and accumulator wrapped around a 4-bit ripple-carry add stage. It accepts a wide operand pair (4·NIBBLES bits) over a valid/ready handshake and feeds one nibble per cycle, LSB first, into a 4-bit add with the same CIN/A/B/SUM/COUT contract as the team's 4-bit ripple adder. It registers the inter-nibble carry and assembles the wide SUM. The result is presented to the downstream consumer on a second valid/ready handshake.

---
 rtl/nibble_serial_adder_if.sv | 36 +++
 rtl/nibble_serial_adder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface nibble_serial_adder_if #(
   parameter int unsigned NIBBLES = 4
);
   localparam int unsigned W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   modport master (
      output in_valid, cin, a, b, out_ready,
      input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, cin, a, b, out_ready,
      output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder that processes one 4-bit nibble per cycle, LSB first, behind valid/ready handshakes.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
   parameter int unsigned NIBBLES = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   nibble_serial_adder_if.slave bus
);
   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          carry_q, carry_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [4:0]    nib_c;
`ifdef SERIAL_ADDER_OVF_EN
   logic          ovf_q, ovf_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      nib_c   = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = RUN;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         RUN: begin
            // Nibble sum enters at the top so the LSB nibble ends up at bit 0.
            sum_d   = W'({nib_c[3:0], sum_q} >> 4);
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            carry_d = nib_c[4];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(NIBBLES - 1)) begin
               cout_d  = nib_c[4];
               state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = (a_q[3] ^ b_q[3] ^ nib_c[3]) ^ nib_c[4];
`endif
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule
